// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types for the pipeline hazard controller
package pipeline_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum {HZ_DRAIN, HZ_RUN, HZ_MEM_WAIT} hz_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// rtl/pipeline_hazard_ctrl_forward_unit.sv - E-stage operand forwarding select
module forward_unit
  import pipeline_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output fwd_sel_t          fwd
);

  // M is the younger producer, so it wins over W; x0 is hardwired zero.
  always_comb begin
    fwd = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs_e))
      fwd = FWD_M;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e))
      fwd = FWD_W;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/forward sequencing for the 5-stage pipeline
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int REG_AW       = 5,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              LoadE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              PCSrcE,
  input  logic              MemReqM,
  input  logic              MemBusyM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [WIDTH-1:0]  stall_cycles
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  hz_state_t        state, state_n;
  logic [DW-1:0]    drain_cnt;
  logic [WIDTH-1:0] stall_cnt;
  logic             lw_stall;
  logic             frozen;
  fwd_sel_t         fwd_a, fwd_b;

  forward_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_e(Rs1E), .rd_m(RdM), .rd_w(RdW),
    .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .fwd(fwd_a)
  );

  forward_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_e(Rs2E), .rd_m(RdM), .rd_w(RdW),
    .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .fwd(fwd_b)
  );

  assign ForwardAE    = fwd_a;
  assign ForwardBE    = fwd_b;
  assign stall_cycles = stall_cnt;

  assign lw_stall = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // Entering the wait takes effect in the same cycle the busy memory is seen.
  assign frozen = ((state == HZ_RUN) && MemReqM && MemBusyM) ||
                  ((state == HZ_MEM_WAIT) && MemBusyM);

  always_comb begin
    state_n = state;
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    StallM  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    FlushW  = 1'b0;
    case (state)
      HZ_DRAIN:    if (drain_cnt == DRAIN_LAST) state_n = HZ_RUN;
      HZ_RUN:      if (MemReqM && MemBusyM) state_n = HZ_MEM_WAIT;
      HZ_MEM_WAIT: if (!MemBusyM) state_n = HZ_RUN;
      default:     state_n = HZ_DRAIN;
    endcase
    if (state == HZ_DRAIN) begin
      StallF = 1'b1;
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (frozen) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      // The D instruction is wrong-path, so a pending load-use stall is moot.
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
    if (!rst_n) begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HZ_DRAIN;
      drain_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_n;
      drain_cnt <= (state == HZ_DRAIN) ? drain_cnt + 1'b1 : '0;
      if (StallF && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
